// File: rtl/jt4701_pkg.sv
// Shared types and constants for the jt4701 quadrature-counter poller.
package jt4701_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_XL1,
    ST_XH,
    ST_XL2,
    ST_YL1,
    ST_YH,
    ST_YL2,
    ST_DONE,
    ST_CLR
  } state_e;

  // Byte-select encodings as {xn_y, uln}
  localparam logic [1:0] SEL_XL = 2'b00;
  localparam logic [1:0] SEL_XH = 2'b01;
  localparam logic [1:0] SEL_YL = 2'b10;
  localparam logic [1:0] SEL_YH = 2'b11;

endpackage

// File: rtl/jt4701_poll_axis.sv
// One axis of the poller: L1/H/L2 byte latches, carry-race detection and the
// snapshot/delta registers.
module jt4701_poll_axis
  import jt4701_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       dout_i,
  input  logic             ld_l1_i,
  input  logic             ld_h_i,
  input  logic             ld_l2_i,
  input  logic             commit_i,
  input  logic             clear_i,
  output logic             carry_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] d_o
);

  // Only the MSB of L1 matters: a flip between L1 and L2 means a carry may have hit H
  logic             l1_msb_q;
  logic [3:0]       h_q;
  logic [7:0]       l2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] d_q;
  logic [CNT_W-1:0] new_s;

  assign carry_o = dout_i[7] ^ l1_msb_q;
  // The Y axis commits on the same edge its L2 byte arrives, so take it live
  assign new_s   = {h_q, (ld_l2_i ? dout_i : l2_q)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1_msb_q <= 1'b0;
      h_q      <= 4'd0;
      l2_q     <= 8'd0;
      cnt_q    <= '0;
      d_q      <= '0;
    end else begin
      if (ld_l1_i) l1_msb_q <= dout_i[7];
      if (ld_h_i)  h_q      <= dout_i[3:0];
      if (ld_l2_i) l2_q     <= dout_i;
      if (clear_i) begin
        cnt_q <= '0;
        d_q   <= '0;
      end else if (commit_i) begin
        cnt_q <= new_s;
        d_q   <= new_s - cnt_q;
      end
    end
  end

  assign cnt_o = cnt_q;
  assign d_o   = d_q;

endmodule

// File: rtl/jt4701_poller.sv
// Scan controller for the uPD4701A-compatible counter: carry-safe byte reads,
// coherent X/Y snapshots with deltas, buttons, and scan-safe counter clears.
module jt4701_poller
  import jt4701_pkg::*;
#(
  parameter int DOUT_LAT  = 2,
  parameter int AUTO_CF   = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_i,
  input  logic             clr_x_i,
  input  logic             clr_y_i,
  input  logic [7:0]       dout_i,
  input  logic             cfn_i,
  input  logic             sfn_i,
  output logic             csn_o,
  output logic             uln_o,
  output logic             xn_y_o,
  output logic             x_rst_o,
  output logic             y_rst_o,
  output logic [CNT_W-1:0] cnt_x_o,
  output logic [CNT_W-1:0] cnt_y_o,
  output logic [CNT_W-1:0] dx_o,
  output logic [CNT_W-1:0] dy_o,
  output logic [2:0]       btn_o,
  output logic             busy_o,
  output logic             valid_o
);

  localparam logic [3:0] LAT       = 4'(DOUT_LAT);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
  localparam bit         AUTO      = (AUTO_CF != 0);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d, retry_q, retry_d;
  logic [1:0] sel_q, sel_d;
  logic       csn_q, csn_d, busy_q, busy_d, valid_q, valid_d;
  logic       x_rst_q, x_rst_d, y_rst_q, y_rst_d;
  logic [2:0] btn_q, btn_d, btn_raw_q, btn_raw_d;
  logic       trig_prev_q, pend_trig_q, pend_trig_d;
  logic       pend_cx_q, pend_cx_d, pend_cy_q, pend_cy_d;
  logic       sample_s, trig_rise_s, commit_s;
  logic       x_ld_l1_s, x_ld_h_s, x_ld_l2_s, x_clear_s, x_carry_s;
  logic       y_ld_l1_s, y_ld_h_s, y_ld_l2_s, y_clear_s, y_carry_s;

  assign sample_s    = (wait_q == LAT);
  assign trig_rise_s = trig_i & ~trig_prev_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    retry_d     = retry_q;
    sel_d       = sel_q;
    csn_d       = csn_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    x_rst_d     = 1'b0;
    y_rst_d     = 1'b0;
    btn_d       = btn_q;
    btn_raw_d   = btn_raw_q;
    pend_trig_d = pend_trig_q | trig_rise_s;
    pend_cx_d   = pend_cx_q | clr_x_i;
    pend_cy_d   = pend_cy_q | clr_y_i;
    commit_s    = 1'b0;
    x_ld_l1_s   = 1'b0;
    x_ld_h_s    = 1'b0;
    x_ld_l2_s   = 1'b0;
    y_ld_l1_s   = 1'b0;
    y_ld_h_s    = 1'b0;
    y_ld_l2_s   = 1'b0;
    x_clear_s   = 1'b0;
    y_clear_s   = 1'b0;

    if (state_q inside {ST_XL1, ST_XH, ST_XL2, ST_YL1, ST_YH, ST_YL2}) begin
      wait_d = sample_s ? 4'd0 : wait_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // Clears take priority over a pending scan
        if (pend_cx_q || pend_cy_q) begin
          state_d   = ST_CLR;
          x_rst_d   = pend_cx_q;
          y_rst_d   = pend_cy_q;
          pend_cx_d = clr_x_i;
          pend_cy_d = clr_y_i;
        end else if (pend_trig_q || (AUTO && !cfn_i)) begin
          state_d     = ST_START;
          csn_d       = 1'b0;
          busy_d      = 1'b1;
          pend_trig_d = trig_rise_s;
        end
      end
      ST_CLR: begin
        state_d   = ST_IDLE;
        x_clear_s = x_rst_q;
        y_clear_s = y_rst_q;
      end
      ST_START: begin
        state_d = ST_XL1;
        sel_d   = SEL_XL;
        wait_d  = 4'd0;
        retry_d = 4'd0;
      end
      ST_XL1: if (sample_s) begin
        x_ld_l1_s = 1'b1;
        state_d   = ST_XH;
        sel_d     = SEL_XH;
      end
      ST_XH: if (sample_s) begin
        x_ld_h_s = 1'b1;
        state_d  = ST_XL2;
        sel_d    = SEL_XL;
      end
      ST_XL2: if (sample_s) begin
        x_ld_l2_s = 1'b1;
        if (x_carry_s && (retry_q < RETRY_MAX)) begin
          x_ld_l1_s = 1'b1;
          retry_d   = retry_q + 4'd1;
          state_d   = ST_XH;
          sel_d     = SEL_XH;
        end else begin
          retry_d = 4'd0;
          state_d = ST_YL1;
          sel_d   = SEL_YL;
        end
      end
      ST_YL1: if (sample_s) begin
        y_ld_l1_s = 1'b1;
        state_d   = ST_YH;
        sel_d     = SEL_YH;
      end
      ST_YH: if (sample_s) begin
        y_ld_h_s  = 1'b1;
        btn_raw_d = ~dout_i[6:4];
        state_d   = ST_YL2;
        sel_d     = SEL_YL;
      end
      ST_YL2: if (sample_s) begin
        y_ld_l2_s = 1'b1;
        if (y_carry_s && (retry_q < RETRY_MAX)) begin
          y_ld_l1_s = 1'b1;
          retry_d   = retry_q + 4'd1;
          state_d   = ST_YH;
          sel_d     = SEL_YH;
        end else begin
          retry_d  = 4'd0;
          commit_s = 1'b1;
          btn_d    = btn_raw_q;
          valid_d  = 1'b1;
          csn_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_q      <= 4'd0;
      retry_q     <= 4'd0;
      sel_q       <= SEL_XL;
      csn_q       <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      x_rst_q     <= 1'b0;
      y_rst_q     <= 1'b0;
      btn_q       <= 3'd0;
      btn_raw_q   <= 3'd0;
      trig_prev_q <= 1'b0;
      pend_trig_q <= 1'b0;
      pend_cx_q   <= 1'b0;
      pend_cy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      retry_q     <= retry_d;
      sel_q       <= sel_d;
      csn_q       <= csn_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      x_rst_q     <= x_rst_d;
      y_rst_q     <= y_rst_d;
      btn_q       <= btn_d;
      btn_raw_q   <= btn_raw_d;
      trig_prev_q <= trig_i;
      pend_trig_q <= pend_trig_d;
      pend_cx_q   <= pend_cx_d;
      pend_cy_q   <= pend_cy_d;
    end
  end

  jt4701_poll_axis u_axis_x (
    .clk      (clk),
    .rst      (rst),
    .dout_i   (dout_i),
    .ld_l1_i  (x_ld_l1_s),
    .ld_h_i   (x_ld_h_s),
    .ld_l2_i  (x_ld_l2_s),
    .commit_i (commit_s),
    .clear_i  (x_clear_s),
    .carry_o  (x_carry_s),
    .cnt_o    (cnt_x_o),
    .d_o      (dx_o)
  );

  jt4701_poll_axis u_axis_y (
    .clk      (clk),
    .rst      (rst),
    .dout_i   (dout_i),
    .ld_l1_i  (y_ld_l1_s),
    .ld_h_i   (y_ld_h_s),
    .ld_l2_i  (y_ld_l2_s),
    .commit_i (commit_s),
    .clear_i  (y_clear_s),
    .carry_o  (y_carry_s),
    .cnt_o    (cnt_y_o),
    .d_o      (dy_o)
  );

  // sfn_i is the chip's switch-change flag; button state comes from the YH byte instead
  assign csn_o   = csn_q;
  assign uln_o   = sel_q[0];
  assign xn_y_o  = sel_q[1];
  assign x_rst_o = x_rst_q;
  assign y_rst_o = y_rst_q;
  assign btn_o   = btn_q;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_jt4701_poller.sv
// Self-checking bench for jt4701_poller: a small counter-chip model with select
// latency drives dout; expected snapshots/deltas come from plain arithmetic.
module tb_jt4701_poller;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst, trig, clr_x, clr_y, cfn, sfn;
  logic [7:0]  dout;
  logic        csn, uln, xn_y, x_rst, y_rst, busy, valid;
  logic [11:0] cnt_x, cnt_y, dx, dy;
  logic [2:0]  btn;

  jt4701_poller #(.DOUT_LAT(LAT), .AUTO_CF(1), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .trig_i(trig), .clr_x_i(clr_x), .clr_y_i(clr_y),
    .dout_i(dout), .cfn_i(cfn), .sfn_i(sfn), .csn_o(csn), .uln_o(uln),
    .xn_y_o(xn_y), .x_rst_o(x_rst), .y_rst_o(y_rst), .cnt_x_o(cnt_x),
    .cnt_y_o(cnt_y), .dx_o(dx), .dy_o(dy), .btn_o(btn), .busy_o(busy),
    .valid_o(valid)
  );

  always #5 clk = ~clk;

  // Counter chip model: data is only valid LAT+ cycles after the select settles
  logic [11:0] cx, cy;
  logic [2:0]  btnn;
  logic [1:0]  last_sel = 2'b00;
  int          age = 15;
  logic [7:0]  chip_byte;
  wire  [1:0]  sel = {xn_y, uln};

  always_comb begin
    case (sel)
      2'b00:   chip_byte = cx[7:0];
      2'b01:   chip_byte = {sfn, btnn, cx[11:8]};
      2'b10:   chip_byte = cy[7:0];
      default: chip_byte = {sfn, btnn, cy[11:8]};
    endcase
  end

  always @(negedge clk) begin
    if (sel != last_sel) age <= 1;
    else if (age < 15) age <= age + 1;
    last_sel <= sel;
  end

  assign dout = (!csn && age > LAT) ? chip_byte : 8'h5A;

  int checks = 0;
  int errors = 0;
  int prev_x = 0;
  int prev_y = 0;
  int lat, xr_seen, pulses;
  logic busy_mid, csn_mid, busy_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Trigger one scan; optionally move X mid-scan, inject clr_x, or re-trigger while busy
  task automatic run_scan(input int chg_cyc, input logic [11:0] chg_x, input int clr_cyc, input bit extra);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    lat = 0; xr_seen = 0; busy_mid = 1'b0; csn_mid = 1'b1; busy_v = 1'b1;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      tick();
      if (n == chg_cyc) cx = chg_x;
      if (n == clr_cyc) clr_x = 1'b1;
      if (n == clr_cyc + 1) clr_x = 1'b0;
      if (extra) trig = (n == 4 || n == 8);
      if (n == 10) begin busy_mid = busy; csn_mid = csn; end
      if (x_rst || y_rst) xr_seen++;
      if (valid) begin lat = n; busy_v = busy; end
    end
    trig = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    lat = 0; csn_mid = 1'b1;
    for (int n = 1; n <= bound && lat == 0; n++) begin
      tick();
      if (n == 10) csn_mid = csn;
      if (valid) lat = n;
    end
  endtask

  task automatic expect_snap(input string tag);
    logic [2:0]  eb;
    logic [11:0] hold_x;
    eb = ~btnn;
    chk({tag, ".cnt_x"}, 32'(cnt_x), 32'(cx));
    chk({tag, ".cnt_y"}, 32'(cnt_y), 32'(cy));
    chk({tag, ".dx"}, 32'(dx), (int'(cx) - prev_x) & 32'hFFF);
    chk({tag, ".dy"}, 32'(dy), (int'(cy) - prev_y) & 32'hFFF);
    chk({tag, ".btn"}, 32'(btn), 32'(eb));
    prev_x = int'(cx);
    prev_y = int'(cy);
    hold_x = cx;
    tick();
    chk({tag, ".valid_1cyc"}, 32'(valid), 32'd0);
    chk({tag, ".cnt_x_hold"}, 32'(cnt_x), 32'(hold_x));
  endtask

  task automatic clear_idle(input bit is_y);
    if (is_y) clr_y = 1'b1; else clr_x = 1'b1;
    tick();
    clr_x = 1'b0; clr_y = 1'b0;
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      pulses += is_y ? int'(y_rst) : int'(x_rst);
    end
    chk("clr_idle.pulses", 32'(pulses), 32'd1);
    if (is_y) begin
      chk("clr_idle.cnt_y", 32'(cnt_y), 32'd0);
      chk("clr_idle.dy", 32'(dy), 32'd0);
      prev_y = 0;
    end else begin
      chk("clr_idle.cnt_x", 32'(cnt_x), 32'd0);
      chk("clr_idle.dx", 32'(dx), 32'd0);
      prev_x = 0;
    end
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; clr_x = 1'b0; clr_y = 1'b0; cfn = 1'b1; sfn = 1'b1;
    cx = 12'h000; cy = 12'h000; btnn = 3'b111;
    repeat (3) tick();
    chk("rst.csn", 32'(csn), 32'd1);
    chk("rst.sel", 32'(sel), 32'd0);
    chk("rst.busy_valid", 32'({busy, valid}), 32'd0);
    chk("rst.clr_outs", 32'({x_rst, y_rst}), 32'd0);
    chk("rst.cnt", 32'({cnt_x, cnt_y}), 32'd0);
    chk("rst.delta", 32'({dx, dy}), 32'd0);
    chk("rst.btn", 32'(btn), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Static counts, first scan
    cx = 12'h123; cy = 12'hABC;
    run_scan(0, 12'h0, 0, 1'b0);
    chk("static.lat", 32'(lat), 32'd20);
    chk("static.busy_mid", 32'(busy_mid), 32'd1);
    chk("static.csn_mid", 32'(csn_mid), 32'd0);
    chk("static.busy_at_valid", 32'(busy_v), 32'd0);
    expect_snap("static");

    // Carry race between XL1 and XL2
    cx = 12'h17F;
    run_scan(9, 12'h180, 0, 1'b0);
    chk("carry.lat", 32'(lat), 32'd26);
    chk("carry.cnt_x", 32'(cnt_x), 32'h180);
    expect_snap("carry");

    // Wrap-around deltas
    cx = 12'hFFF; cy = 12'h001;
    run_scan(0, 12'h0, 0, 1'b0);
    expect_snap("wrap_a");
    cx = 12'h002; cy = 12'hFFF;
    run_scan(0, 12'h0, 0, 1'b0);
    chk("wrap.dx", 32'(dx), 32'h003);
    chk("wrap.dy", 32'(dy), 32'hFFE);
    expect_snap("wrap_b");

    // clr_x during a scan is deferred until after valid
    cx = 12'h456;
    run_scan(0, 12'h0, 5, 1'b0);
    chk("clrscan.lat", 32'(lat), 32'd20);
    chk("clrscan.no_rst_in_scan", 32'(xr_seen), 32'd0);
    expect_snap("clrscan");
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      pulses += int'(x_rst);
      if (y_rst) pulses += 100;
    end
    chk("clrscan.x_rst_pulses", 32'(pulses), 32'd1);
    chk("clrscan.cnt_x", 32'(cnt_x), 32'd0);
    chk("clrscan.dx", 32'(dx), 32'd0);
    chk("clrscan.cnt_y_kept", 32'(cnt_y), 32'(cy));
    cx = 12'h000; prev_x = 0;
    run_scan(0, 12'h0, 0, 1'b0);
    expect_snap("after_clr");

    // Two triggers while busy collapse into exactly one extra scan
    cx = 12'h321; cy = 12'h654;
    run_scan(0, 12'h0, 0, 1'b1);
    chk("retrig.lat", 32'(lat), 32'd20);
    expect_snap("retrig_1");
    wait_valid(40);
    chk("retrig.second_lat", 32'(lat), 32'd20);
    expect_snap("retrig_2");
    wait_valid(40);
    chk("retrig.no_third", 32'(lat), 32'd0);

    // Randomized scans with occasional idle clears
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) clear_idle(1'($urandom_range(0, 1)));
      cx = 12'($urandom); cy = 12'($urandom); btnn = 3'($urandom_range(0, 7));
      run_scan(0, 12'h0, 0, 1'b0);
      chk("rand.lat", 32'(lat), 32'd20);
      expect_snap("rand");
    end

    // Auto scans from a low counter flag, left+middle pressed
    cx = 12'h0F0; cy = 12'h707; btnn = 3'b010;
    cfn = 1'b0;
    wait_valid(60);
    chk("auto.lat", 32'(lat), 32'd20);
    chk("auto.csn_mid", 32'(csn_mid), 32'd0);
    chk("auto.btn", 32'(btn), 32'b101);
    expect_snap("auto_1");
    wait_valid(60);
    chk("auto.back_to_back", 32'(lat), 32'd20);
    chk("auto.csn_mid2", 32'(csn_mid), 32'd0);
    cfn = 1'b1;
    expect_snap("auto_2");
    wait_valid(40);
    chk("auto.stopped", 32'(lat), 32'd0);

    // Reset during the YH read
    cx = 12'h9A5; cy = 12'h5C3; btnn = 3'b111;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    #1;
    chk("midrst.csn", 32'(csn), 32'd1);
    chk("midrst.busy_valid", 32'({busy, valid}), 32'd0);
    chk("midrst.cnt", 32'({cnt_x, cnt_y}), 32'd0);
    chk("midrst.delta", 32'({dx, dy}), 32'd0);
    chk("midrst.btn", 32'(btn), 32'd0);
    tick();
    rst = 1'b0;
    prev_x = 0; prev_y = 0;
    wait_valid(30);
    chk("midrst.no_valid", 32'(lat), 32'd0);
    run_scan(0, 12'h0, 0, 1'b0);
    chk("midrst.lat", 32'(lat), 32'd20);
    expect_snap("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
